fpmul_result_collector: RTL and testbench
=========================================

Name: fpmul_result_collector

Overview:
Receive-side companion to the stimulus source in the FP multiplier bench. Taps the operand stream driven onto FP_A/FP_B and the multiplier's FP_Z output. Re-aligns each operand with its result through a latency-matched delay line, checks the result, and buffers {operand, result} pairs in a FIFO. A downstream logger or scoreboard drains the FIFO over a valid/ready handshake.

Parameters:
WIDTH, 32, FP word width (IEEE-754 single)
LATENCY, 4, FPmul pipeline depth in cycles, from operand sample to valid FP_Z; must be >= 1
DEPTH, 8, pair FIFO entries; power of two, >= 2

Ports:
CLK  in  1  bench clock
RST_N  in  1  reset, asynchronous, active-low
EN  in  1  operand on DIN is valid this cycle
DIN  in  WIDTH  operand as applied to both FP_A and FP_B
DOUT  in  WIDTH  multiplier result FP_Z
CLR  in  1  synchronous clear of flags and counter
PAIR_VALID  out  1  FIFO head valid
PAIR_READY  in  1  consumer accepts head
PAIR_OP  out  WIDTH  head operand
PAIR_RES  out  WIDTH  head result
PAIR_CNT  out  16  pairs accepted since reset/CLR, saturating
SIGN_ERR  out  1  sticky: square with negative, non-NaN result
OVERFLOW  out  1  sticky: pair dropped because FIFO full

Behaviour:
- Reset (async, RST_N=0): delay-line valid bits, FIFO pointers/count, PAIR_CNT, SIGN_ERR, OVERFLOW all 0. PAIR_VALID=0. PAIR_OP/PAIR_RES=0. In-flight operands are discarded. Release is sampled on the next CLK rising edge.
- Delay line: LATENCY-stage shift register of {EN, DIN}, advances every cycle. Tap = stage LATENCY-1, i.e. the operand sampled LATENCY cycles earlier. The tap is paired with DOUT in the same cycle.
- Push: tap valid AND (not full OR pop this cycle).
- Drop: tap valid AND full AND no pop. The pair is lost and OVERFLOW is set.
- Pop: PAIR_VALID AND PAIR_READY.
- Simultaneous push and pop when full: both occur; occupancy is unchanged.
- FIFO is registered, with no fall-through. A push into an empty FIFO gives PAIR_VALID=1 on the next cycle.
- PAIR_OP/PAIR_RES hold stable while PAIR_VALID=1 and PAIR_READY=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits. Full = count==DEPTH; empty = count==0.
- Check, evaluated on each push: result sign=1 AND NOT(exp==8'hFF AND mant!=0) sets SIGN_ERR. The bench squares its operands, so any non-NaN result must be non-negative.
- PAIR_CNT increments on every accepted push and saturates at 16'hFFFF.
- Drops do not increment PAIR_CNT.
- CLR=1: PAIR_CNT<=0, SIGN_ERR<=0, OVERFLOW<=0. FIFO contents are untouched.
- CLR in the same cycle as an event: the event wins. A push loads PAIR_CNT=1; an error or drop leaves its flag set. No error is lost.
- Startup: the first LATENCY cycles after reset produce no pushes, whatever DOUT carries.

Decomposition:
- Shared header fpmul_tb_pkg: FP_W=32, EXP_MSB=30, EXP_LSB=23, SIGN_BIT=31, EXP_ALL_ONES=8'hFF, is_nan function.
- One sub-module, pair_fifo: generic synchronous FIFO with WIDTH=2*FP_W and DEPTH. It provides push, pop, full, empty, and head outputs.
- Delay line, checker and counters stay in the top.

Test Plan:
- Startup: EN=1, DIN=32'h3F800000 every cycle, DOUT=32'h3F800000 from cycle LATENCY, PAIR_READY=1 -> no PAIR_VALID for LATENCY+1 cycles after reset, then pairs {3F800000,3F800000}, PAIR_CNT counts up, SIGN_ERR=0.
- Alignment: DIN sequence 40000000, C0400000 with DOUT 40800000, 41100000 delayed LATENCY -> pairs {40000000,40800000}, {C0400000,41100000} in order, SIGN_ERR=0.
- Sign check: tap operand C0400000 with DOUT forced C1100000 -> SIGN_ERR=1 and stays 1. DOUT FFC00000 (NaN) in a fresh run -> SIGN_ERR stays 0.
- Backpressure/overflow: PAIR_READY=0, continuous EN=1 -> PAIR_CNT=DEPTH=8, then OVERFLOW=1 on pair 9; head is stable. Raising PAIR_READY drains exactly 8 pairs in order.
- Full with simultaneous push and pop: FIFO full, PAIR_READY=1 for one cycle with tap valid -> push accepted, OVERFLOW stays 0, PAIR_CNT=9, occupancy stays 8.
- Reset and CLR: RST_N=0 mid-stream with 5 pairs buffered -> PAIR_VALID=0 and counters 0 immediately, with no stale pairs after release. CLR asserted together with an erroneous push -> SIGN_ERR=1, PAIR_CNT=1.

Source files
------------

// File: rtl/fpmul_tb_pkg.sv
// Shared FP field definitions and the {operand, result} pair payload for the FP multiplier bench.
package fpmul_tb_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned SIGN_BIT = 31;
  localparam logic [EXP_MSB-EXP_LSB:0] EXP_ALL_ONES = 8'hFF;

  typedef struct packed {
    logic [FP_W-1:0] op;
    logic [FP_W-1:0] res;
  } pair_t;

  function automatic logic is_nan(input logic [FP_W-1:0] x);
    return (x[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (x[EXP_LSB-1:0] != '0);
  endfunction

  // A square can only legitimately be negative if it is a NaN carrying a sign bit.
  function automatic logic is_neg_num(input logic [FP_W-1:0] x);
    return x[SIGN_BIT] && !is_nan(x);
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Registered synchronous FIFO, no fall-through; head is the entry at the read pointer.
module pair_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) count_nxt = count + CNT_W'(1);
    if (!do_push && do_pop) count_nxt = count - CNT_W'(1);
  end

  // Flags are registered from the next occupancy so they align with the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/fpmul_result_collector.sv
// Aligns each squared operand with its FPmul result, checks the sign, and buffers the pair
// for a valid/ready consumer.
module fpmul_result_collector
  import fpmul_tb_pkg::*;
#(
  parameter int unsigned WIDTH   = FP_W,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIN,
  input  logic [WIDTH-1:0] DOUT,
  input  logic             CLR,
  output logic             PAIR_VALID,
  input  logic             PAIR_READY,
  output logic [WIDTH-1:0] PAIR_OP,
  output logic [WIDTH-1:0] PAIR_RES,
  output logic [15:0]      PAIR_CNT,
  output logic             SIGN_ERR,
  output logic             OVERFLOW
);

  localparam int unsigned PAIR_W = $bits(pair_t);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [LATENCY-1:0] dl_vld;
  logic [WIDTH-1:0]   dl_dat [LATENCY];
  logic               tap_vld;
  logic               push;
  logic               pop;
  logic               drop;
  logic               full;
  logic               empty;
  logic               err;
  pair_t              wr_pair;
  pair_t              head;

  // Operand delay line matching the multiplier pipeline depth.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dl_vld <= '0;
      for (int i = 0; i < int'(LATENCY); i++) dl_dat[i] <= '0;
    end else begin
      dl_vld[0] <= EN;
      dl_dat[0] <= DIN;
      for (int i = 1; i < int'(LATENCY); i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_dat[i] <= dl_dat[i-1];
      end
    end
  end

  assign tap_vld     = dl_vld[LATENCY-1];
  assign wr_pair.op  = FP_W'(dl_dat[LATENCY-1]);
  assign wr_pair.res = FP_W'(DOUT);

  assign pop  = PAIR_VALID && PAIR_READY;
  assign push = tap_vld && (!full || pop);
  assign drop = tap_vld && full && !pop;
  assign err  = push && is_neg_num(FP_W'(DOUT));

  pair_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .pop   (pop),
    .data  (wr_pair),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign PAIR_VALID = !empty;
  assign PAIR_OP    = WIDTH'(head.op);
  assign PAIR_RES   = WIDTH'(head.res);

  // A same-cycle event overrides CLR, so no push, error or drop is ever lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PAIR_CNT <= '0;
      SIGN_ERR <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) begin
        if (CLR)                       PAIR_CNT <= 16'd1;
        else if (PAIR_CNT != CNT_MAX)  PAIR_CNT <= PAIR_CNT + 16'd1;
      end else if (CLR) begin
        PAIR_CNT <= '0;
      end
      SIGN_ERR <= (SIGN_ERR && !CLR) || err;
      OVERFLOW <= (OVERFLOW && !CLR) || drop;
    end
  end

endmodule

// File: tb/tb_fpmul_result_collector.sv
// Randomized and directed bench for fpmul_result_collector against a queue-based pairing model.
module tb_fpmul_result_collector;

  localparam int L = 4;
  localparam int D = 8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        EN = 1'b0;
  logic [31:0] DIN = '0;
  logic [31:0] DOUT = '0;
  logic        CLR = 1'b0;
  logic        PAIR_READY = 1'b0;
  logic        PAIR_VALID;
  logic [31:0] PAIR_OP;
  logic [31:0] PAIR_RES;
  logic [15:0] PAIR_CNT;
  logic        SIGN_ERR;
  logic        OVERFLOW;

  fpmul_result_collector #(.WIDTH(32), .LATENCY(L), .DEPTH(D)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .DIN        (DIN),
    .DOUT       (DOUT),
    .CLR        (CLR),
    .PAIR_VALID (PAIR_VALID),
    .PAIR_READY (PAIR_READY),
    .PAIR_OP    (PAIR_OP),
    .PAIR_RES   (PAIR_RES),
    .PAIR_CNT   (PAIR_CNT),
    .SIGN_ERR   (SIGN_ERR),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: operand history since reset, pair queue, counters and flags.
  bit          h_en[$];
  bit [31:0]   h_din[$];
  bit [63:0]   mq[$];
  int unsigned m_cnt;
  bit          m_serr;
  bit          m_ovf;
  int          n_step;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit neg_non_nan(input bit [31:0] r);
    return r[31] && !(r[30:23] == 8'hFF && r[22:0] != 0);
  endfunction

  function automatic bit [31:0] rand_pos();
    bit [31:0] v;
    v = $urandom;
    v[31] = 1'b0;
    return v;
  endfunction

  task automatic compare_all();
    check("valid", PAIR_VALID, mq.size() != 0);
    if (mq.size() != 0) begin
      check("op", PAIR_OP, mq[0][63:32]);
      check("res", PAIR_RES, mq[0][31:0]);
    end
    check("cnt", PAIR_CNT, m_cnt);
    check("sign_err", SIGN_ERR, m_serr);
    check("overflow", OVERFLOW, m_ovf);
  endtask

  // One clock: drive inputs, predict the edge from the spec rules, then compare.
  task automatic step(input bit en, input bit [31:0] din, input bit [31:0] dout,
                      input bit rdy, input bit clr);
    bit tap_v, pop, push, drop;
    bit [31:0] tap_d;
    EN = en; DIN = din; DOUT = dout; PAIR_READY = rdy; CLR = clr;
    tap_v = (n_step >= L) ? h_en[n_step-L] : 1'b0;
    tap_d = (n_step >= L) ? h_din[n_step-L] : 32'h0;
    h_en.push_back(en);
    h_din.push_back(din);
    pop  = (mq.size() != 0) && rdy;
    push = tap_v && ((mq.size() < D) || pop);
    drop = tap_v && !push;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({tap_d, dout});
    if (clr) begin m_cnt = 0; m_serr = 0; m_ovf = 0; end
    if (push && m_cnt < 65535) m_cnt++;
    if (push && neg_non_nan(dout)) m_serr = 1;
    if (drop) m_ovf = 1;
    n_step++;
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    RST_N = 1'b0; EN = 1'b0; CLR = 1'b0; PAIR_READY = 1'b0; DIN = '0; DOUT = '0;
    #1;
    check("rst_valid", PAIR_VALID, 1'b0);
    check("rst_cnt", PAIR_CNT, 16'd0);
    check("rst_sign_err", SIGN_ERR, 1'b0);
    check("rst_overflow", OVERFLOW, 1'b0);
    check("rst_op", PAIR_OP, 32'd0);
    check("rst_res", PAIR_RES, 32'd0);
    h_en.delete(); h_din.delete(); mq.delete();
    m_cnt = 0; m_serr = 0; m_ovf = 0; n_step = 0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic fill_case(input bit pop_at_full);
    int n_pop;
    do_reset();
    for (int i = 0; i < 13; i++)
      step(i < 9, 32'h3F800000 + 32'(i), rand_pos(), (i == 12) && pop_at_full, 1'b0);
    check(pop_at_full ? "full_pp_cnt" : "ovf_cnt", PAIR_CNT, pop_at_full ? 16'd9 : 16'd8);
    check(pop_at_full ? "full_pp_ovf" : "ovf_flag", OVERFLOW, !pop_at_full);
    n_pop = 0;
    for (int i = 0; i < 12; i++) begin
      if (PAIR_VALID) n_pop++;
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    check("drain_pops", n_pop, 8);
  endtask

  initial begin
    bit [31:0] dv;
    #3;
    // Startup: nothing may be paired before the pipeline fills, even with negative DOUT.
    do_reset();
    for (int i = 0; i < 12; i++)
      step(1'b1, 32'h3F800000, (i >= L) ? 32'h3F800000 : 32'hC0000000, 1'b1, 1'b0);
    check("startup_cnt", PAIR_CNT, 16'd8);
    check("startup_sign", SIGN_ERR, 1'b0);

    // Alignment with the consumer stalled, then popped one at a time.
    do_reset();
    for (int i = 0; i < 8; i++)
      step(i < 2, (i == 0) ? 32'h40000000 : (i == 1) ? 32'hC0400000 : 32'h0,
           (i == 4) ? 32'h40800000 : (i == 5) ? 32'h41100000 : 32'h0, 1'b0, 1'b0);
    check("align_op0", PAIR_OP, 32'h40000000);
    check("align_res0", PAIR_RES, 32'h40800000);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("align_op1", PAIR_OP, 32'hC0400000);
    check("align_res1", PAIR_RES, 32'h41100000);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Negative non-NaN square sets a sticky error; a negative NaN does not.
    do_reset();
    for (int i = 0; i < 9; i++)
      step(i == 0, 32'hC0400000, (i == L) ? 32'hC1100000 : 32'h0, 1'b1, 1'b0);
    check("sign_sticky", SIGN_ERR, 1'b1);
    do_reset();
    for (int i = 0; i < 9; i++)
      step(i == 0, 32'hC0400000, (i == L) ? 32'hFFC00000 : 32'h0, 1'b1, 1'b0);
    check("sign_nan", SIGN_ERR, 1'b0);

    fill_case(1'b0);
    fill_case(1'b1);

    // Asynchronous reset with five pairs buffered and operands in flight.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, $urandom, rand_pos(), 1'b0, 1'b0);
    check("mid_buffered", PAIR_CNT, 16'd5);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("mid_no_stale", PAIR_VALID, 1'b0);

    // CLR coinciding with an erroneous push, then CLR alone.
    do_reset();
    for (int i = 0; i <= L; i++)
      step(i == 0, 32'hC0400000, (i == L) ? 32'hC1100000 : 32'h0, 1'b0, i == L);
    check("clr_evt_sign", SIGN_ERR, 1'b1);
    check("clr_evt_cnt", PAIR_CNT, 16'd1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("clr_sign", SIGN_ERR, 1'b0);
    check("clr_cnt", PAIR_CNT, 16'd0);
    check("clr_keeps_fifo", PAIR_VALID, 1'b1);

    // Random traffic: backpressure, occasional bad/NaN results and CLR pulses.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      dv = rand_pos();
      if ($urandom_range(31) == 0) dv[31] = 1'b1;
      if ($urandom_range(31) == 0) dv = 32'hFFC00000 | ($urandom & 32'h003FFFFF);
      step($urandom_range(3) != 0, $urandom, dv, $urandom_range(1) == 1,
           $urandom_range(49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
